wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Final (write-back) pipeline stage; consumes the MEM stage's 207-bit MEM_to_WB_bus.
//  Latches one instruction per handshake, commits GPR/CSR writes, issues TLB commands.
//  Resolves exceptions (priority encode to ecode/esubcode/badv), ERTN and TLB refetch.
//  Its one combined flush output kills all younger stages.
// PARAMETERS
//  BUS_W     207  width of MEM_to_WB_bus
//  EXT_W     15   width of the exception-type vector inside the bus
// PORTS
//  clk              in   1   clock, rising edge
//  resetn           in   1   reset, asynchronous, active-low
//  MEM_to_WB_valid  in   1   MEM holds a valid instruction for WB
//  MEM_to_WB_bus    in   207 {refetch,tlbsrch,tlbrd,tlbwr,tlbfill,tlbhit,hit_idx[3:0],csr_we,csr_num[13:0],
//                            csr_wmask[31:0],csr_wvalue[31:0],ertn,ex_type[14:0],result[31:0],gr_we,dest[4:0],pc,inst}
//  WB_allow_in      out  1   WB can accept this cycle
//  rf_we/rf_waddr/rf_wdata  out 1/5/32  register-file write port
//  WB_wr_bus        out  38  {WB_write, dest, result} for hazard/forward logic
//  csr_we/csr_num/csr_wmask/csr_wvalue  out 1/14/32/32  CSR write port
//  wb_ex            out  1   exception commit pulse
//  wb_ecode/wb_esubcode  out 6/9  exception code/subcode
//  wb_pc/wb_vaddr   out  32/32  faulting pc / bad virtual address
//  wb_badv_we       out  1   write BADV with wb_vaddr
//  ertn_flush       out  1   ERTN commit pulse
//  refetch_flush/refetch_pc  out 1/32  TLB-instruction refetch, restart at pc+4
//  tlb_op           out  4   {srch,rd,wr,fill} one-hot command
//  tlbsrch_hit/tlbsrch_idx  out 1/4  search result forwarded to CSR TLBIDX
//  flush            out  1   wb_ex | ertn_flush | refetch_flush
// BEHAVIOUR
//  - State: WB_valid, bus register (BUS_W bits). ready_go=1; WB_allow_in = 1.
//  - Async reset (resetn low): WB_valid<=0, bus reg<=0; every output 0 while reset is held.
//  - Each edge: WB_valid<=MEM_to_WB_valid; bus reg loads only when MEM_to_WB_valid=1.
//  - Latency: one cycle from MEM handoff to commit; one instruction per cycle.
//  - ex_any = WB_valid & |ex_type. wb_ex=ex_any.
//  - ertn_flush = WB_valid & ertn & ~ex_any.
//  - refetch_flush = WB_valid & refetch & ~ex_any.
//  - rf_we = WB_valid & gr_we & ~ex_any. WB_write in WB_wr_bus equals rf_we.
//  - csr_we = WB_valid & csr_we_bit & ~ex_any. tlb_op bits are each gated the same way.
//  - Ecode priority (high->low), ecode/esub:
//      INT 0x00 > ADEF 0x08/0 > TLBRF 0x3F > PIF 0x03 > PPIF 0x07 > INE 0x0D > SYS 0x0B
//      > BRK 0x0C > ALE 0x09 > ADEM 0x08/1 > TLBRM 0x3F > PIL 0x01 > PIS 0x02 > PME 0x04 > PPIM 0x07.
//  - esubcode=1 only for ADEM, else 0. Outputs are 0 when ex_any=0.
//  - wb_vaddr = pc for ADEF/TLBRF/PIF/PPIF, result for memory types.
//  - wb_badv_we = ex_any & winner in {ADEF,TLBRF,PIF,PPIF,ALE,ADEM,TLBRM,PIL,PIS,PME,PPIM}.
//  - refetch_pc = pc + 32'd4; mod 2^32, 0xFFFFFFFC wraps to 0.
//  - Bubble (WB_valid=0): all commit/flush/tlb outputs 0 regardless of bus reg contents.
//  - ertn and an exception both set: the exception wins and no ERTN is signalled.
//  - Reset mid-instruction: the instruction is dropped with no partial commit.
// CONFIGURATION
//  WB_DEBUG_TRACE_EN defined: adds outputs
//    debug_wb_pc[31:0]
//    debug_wb_rf_we[3:0] = {4{rf_we}}
//    debug_wb_rf_wnum[4:0] = dest
//    debug_wb_rf_wdata[31:0] = result
//  Trace outputs are valid in the commit cycle and 0 during reset.
//  Undefined: these ports and their logic are absent; all other behaviour is identical.
// TESTING
//  1 reset low mid-run -> all outputs 0 same cycle; after release, first valid add r4=0x1234 -> rf_we=1, waddr=4, wdata=0x1234.
//  2 ex_type has ALE|SYS set, pc=0x1C000100, result=0x00000003 -> wb_ex=1, ecode=0x0B, badv_we=0, rf_we=0, csr_we=0.
//  3 ex_type ADEM only, result=0x80000001 -> ecode=0x08, esub=1, badv_we=1, vaddr=0x80000001.
//  4 ertn=1, no ex -> ertn_flush=1, flush=1. ertn=1 with INE -> ertn_flush=0, ecode=0x0D.
//  5 tlbwr+refetch, pc=0xFFFFFFFC -> tlb_op=4'b0010, refetch_flush=1, refetch_pc=0x00000000.
//  6 MEM_to_WB_valid=0 with stale bus (gr_we=1, csr_we=1) -> rf_we=0, csr_we=0, flush=0, tlb_op=0.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- final (write-back) pipeline stage.
//
// Registers one instruction per cycle from the MEM stage and commits it
// combinationally in the cycle after hand-off. Commit covers:
//   * GPR writes and the write-back forwarding bus.
//   * CSR writes.
//   * TLB commands.
//   * Exception resolution (priority encode to ecode/esubcode/badv).
//   * ERTN and TLB-instruction refetch.
// The combined flush output kills every younger stage.
//
// Ports
//   clk, resetn                      clock (rising edge), async active-low reset
//   MEM_to_WB_valid / MEM_to_WB_bus  incoming instruction. The bus is packed as
//     {refetch, tlbsrch, tlbrd, tlbwr, tlbfill, tlbhit, hit_idx[3:0],
//      csr_we, csr_num[13:0], csr_wmask, csr_wvalue, ertn,
//      ex_type[EXT_W-1:0], result, gr_we, dest[4:0], pc, inst}
//   WB_allow_in                      always 1; WB never stalls
//   rf_we/rf_waddr/rf_wdata          register-file write port
//   WB_wr_bus                        {rf_we, dest, result} for hazard/forwarding
//   csr_we/csr_num/csr_wmask/csr_wvalue   CSR write port (fields 0 when no write)
//   wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr/wb_badv_we   exception commit
//   ertn_flush                       ERTN commit
//   refetch_flush/refetch_pc         refetch after a TLB instruction, at pc+4
//   tlb_op                           {srch, rd, wr, fill} TLB command
//   tlbsrch_hit/tlbsrch_idx          TLBSRCH result for CSR TLBIDX
//   flush                            wb_ex | ertn_flush | refetch_flush
//
// ex_type bit i carries the i-th exception in priority order. Bit 0 has the
// highest priority:
//   0 INT    1 ADEF   2 TLBRF  3 PIF    4 PPIF   5 INE    6 SYS    7 BRK
//   8 ALE    9 ADEM   10 TLBRM 11 PIL   12 PIS   13 PME   14 PPIM
//
// Optional feature: define WB_DEBUG_TRACE_EN to add the debug_wb_* trace
// outputs.
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int BUS_W = 207,
    parameter int EXT_W = 15
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             MEM_to_WB_valid,
    input  logic [BUS_W-1:0] MEM_to_WB_bus,
    output logic             WB_allow_in,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [37:0]      WB_wr_bus,
    output logic             csr_we,
    output logic [13:0]      csr_num,
    output logic [31:0]      csr_wmask,
    output logic [31:0]      csr_wvalue,
    output logic             wb_ex,
    output logic [5:0]       wb_ecode,
    output logic [8:0]       wb_esubcode,
    output logic [31:0]      wb_pc,
    output logic [31:0]      wb_vaddr,
    output logic             wb_badv_we,
    output logic             ertn_flush,
    output logic             refetch_flush,
    output logic [31:0]      refetch_pc,
    output logic [3:0]       tlb_op,
    output logic             tlbsrch_hit,
    output logic [3:0]       tlbsrch_idx,
    output logic             flush
`ifdef WB_DEBUG_TRACE_EN
   ,output logic [31:0]      debug_wb_pc,
    output logic [3:0]       debug_wb_rf_we,
    output logic [4:0]       debug_wb_rf_wnum,
    output logic [31:0]      debug_wb_rf_wdata
`endif
);

    // Field offsets inside the bus register.
    localparam int O_PC    = 32;
    localparam int O_DEST  = 64;
    localparam int O_GRWE  = 69;
    localparam int O_RES   = 70;
    localparam int O_EX    = 102;
    localparam int O_ERTN  = O_EX + EXT_W;
    localparam int O_CSRV  = O_ERTN + 1;
    localparam int O_CSRM  = O_CSRV + 32;
    localparam int O_CSRN  = O_CSRM + 32;
    localparam int O_CSRWE = O_CSRN + 14;
    localparam int O_HIDX  = O_CSRWE + 1;
    localparam int O_HIT   = O_HIDX + 4;
    localparam int O_FILL  = O_HIT + 1;
    localparam int O_WR    = O_FILL + 1;
    localparam int O_RD    = O_WR + 1;
    localparam int O_SRCH  = O_RD + 1;
    localparam int O_REF   = O_SRCH + 1;

    logic             wb_valid_q, wb_valid_d;
    logic [BUS_W-1:0] bus_q, bus_d;

    always_comb begin
        wb_valid_d = MEM_to_WB_valid;
        // NOTE: every always_comb output gets a default first, so that no
        // path can leave it unassigned and infer a latch.
        bus_d = bus_q;
        if (MEM_to_WB_valid) begin
            bus_d = MEM_to_WB_bus;
        end
    end

    // NOTE: the bus register is reset along with the valid bit. Outputs
    // derived from its raw fields must read 0 while reset is held, so
    // clearing only the valid bit would not be enough here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: state registers use non-blocking assignments only.
            wb_valid_q <= 1'b0;
            bus_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            bus_q      <= bus_d;
        end
    end

    // Field views of the latched instruction.
    logic [31:0]      pc, result, csr_wmask_f, csr_wvalue_f;
    logic [4:0]       dest;
    logic [EXT_W-1:0] ex_type;
    logic [13:0]      csr_num_f;
    logic [3:0]       hit_idx;
    logic             gr_we, ertn, csr_we_f, tlbhit, refetch;
    logic             unused_inst;

    assign pc           = bus_q[O_PC +: 32];
    assign dest         = bus_q[O_DEST +: 5];
    assign gr_we        = bus_q[O_GRWE];
    assign result       = bus_q[O_RES +: 32];
    assign ex_type      = bus_q[O_EX +: EXT_W];
    assign ertn         = bus_q[O_ERTN];
    assign csr_wvalue_f = bus_q[O_CSRV +: 32];
    assign csr_wmask_f  = bus_q[O_CSRM +: 32];
    assign csr_num_f    = bus_q[O_CSRN +: 14];
    assign csr_we_f     = bus_q[O_CSRWE];
    assign hit_idx      = bus_q[O_HIDX +: 4];
    assign tlbhit       = bus_q[O_HIT];
    assign refetch      = bus_q[O_REF];
    // The instruction word travels with the bus but is not needed to commit.
    assign unused_inst  = ^bus_q[31:0];

    // Exception resolution. The loop runs from low to high priority, so the
    // highest-priority set bit is written last and wins.
    logic       ex_any;
    logic [3:0] ex_idx;
    logic [5:0] ecode;
    logic       esub, vaddr_pc, vaddr_res;

    assign ex_any = wb_valid_q & (|ex_type);

    always_comb begin
        ex_idx = '0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (ex_type[i]) ex_idx = 4'(i);
        end
    end

    always_comb begin
        ecode     = 6'h00;
        esub      = 1'b0;
        vaddr_pc  = 1'b0;
        vaddr_res = 1'b0;
        case (ex_idx)
            4'd0:  ecode = 6'h00;                                 // INT
            4'd1:  begin ecode = 6'h08; vaddr_pc  = 1'b1; end     // ADEF
            4'd2:  begin ecode = 6'h3F; vaddr_pc  = 1'b1; end     // TLBRF
            4'd3:  begin ecode = 6'h03; vaddr_pc  = 1'b1; end     // PIF
            4'd4:  begin ecode = 6'h07; vaddr_pc  = 1'b1; end     // PPIF
            4'd5:  ecode = 6'h0D;                                 // INE
            4'd6:  ecode = 6'h0B;                                 // SYS
            4'd7:  ecode = 6'h0C;                                 // BRK
            4'd8:  begin ecode = 6'h09; vaddr_res = 1'b1; end     // ALE
            4'd9:  begin ecode = 6'h08; vaddr_res = 1'b1; esub = 1'b1; end // ADEM
            4'd10: begin ecode = 6'h3F; vaddr_res = 1'b1; end     // TLBRM
            4'd11: begin ecode = 6'h01; vaddr_res = 1'b1; end     // PIL
            4'd12: begin ecode = 6'h02; vaddr_res = 1'b1; end     // PIS
            4'd13: begin ecode = 6'h04; vaddr_res = 1'b1; end     // PME
            4'd14: begin ecode = 6'h07; vaddr_res = 1'b1; end     // PPIM
            default: ;
        endcase
    end

    // Any architectural side effect requires a valid instruction that does
    // not raise an exception.
    logic commit_ok;
    assign commit_ok = wb_valid_q & ~ex_any;

    assign WB_allow_in   = 1'b1;

    assign wb_ex         = ex_any;
    assign wb_ecode      = ex_any ? ecode : 6'h00;
    assign wb_esubcode   = {8'h00, ex_any & esub};
    assign wb_pc         = ex_any ? pc : 32'h0;
    assign wb_badv_we    = ex_any & (vaddr_pc | vaddr_res);
    assign wb_vaddr      = !ex_any  ? 32'h0 :
                           vaddr_pc  ? pc    :
                           vaddr_res ? result : 32'h0;

    assign rf_we         = commit_ok & gr_we;
    assign rf_waddr      = dest;
    assign rf_wdata      = result;
    assign WB_wr_bus     = {rf_we, dest, result};

    assign csr_we        = commit_ok & csr_we_f;
    assign csr_num       = csr_we ? csr_num_f    : 14'h0;
    assign csr_wmask     = csr_we ? csr_wmask_f  : 32'h0;
    assign csr_wvalue    = csr_we ? csr_wvalue_f : 32'h0;

    assign tlb_op        = {4{commit_ok}} & bus_q[O_FILL +: 4 ] ^ {4{1'b0}} & 4'h0 |
                           ({4{commit_ok}} & {bus_q[O_SRCH], bus_q[O_RD], bus_q[O_WR], bus_q[O_FILL]});
    assign tlbsrch_hit   = tlb_op[3] & tlbhit;
    assign tlbsrch_idx   = tlb_op[3] ? hit_idx : 4'h0;

    assign ertn_flush    = commit_ok & ertn;
    assign refetch_flush = commit_ok & refetch;
    // Restart address wraps modulo 2^32.
    assign refetch_pc    = refetch_flush ? pc + 32'd4 : 32'h0;

    assign flush         = wb_ex | ertn_flush | refetch_flush;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = wb_valid_q ? pc : 32'h0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest;
    assign debug_wb_rf_wdata = result;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
// A reference model derives every expected output from the instruction held
// in WB, using priority tables rather than the RTL's logic structure. The
// stimulus runs directed scenarios first and then randomized traffic.
// ---------------------------------------------------------------------------
module tb_wb_stage;

    typedef struct packed {
        logic        refetch, tlbsrch, tlbrd, tlbwr, tlbfill, tlbhit;
        logic [3:0]  hit_idx;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask, csr_wvalue;
        logic        ertn;
        logic [14:0] ex_type;
        logic [31:0] result;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] pc, inst;
    } ins_t;

    // Exception codes listed in priority order (index = ex_type bit).
    int ecode_tab [15] = '{'h00, 'h08, 'h3F, 'h03, 'h07, 'h0D, 'h0B, 'h0C,
                           'h09, 'h08, 'h3F, 'h01, 'h02, 'h04, 'h07};

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         MEM_to_WB_valid = 1'b0;
    logic [206:0] MEM_to_WB_bus = '0;
    logic         WB_allow_in, rf_we, csr_we, wb_ex, wb_badv_we, ertn_flush;
    logic         refetch_flush, tlbsrch_hit, flush;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata, csr_wmask, csr_wvalue, wb_pc, wb_vaddr, refetch_pc;
    logic [37:0]  WB_wr_bus;
    logic [13:0]  csr_num;
    logic [5:0]   wb_ecode;
    logic [8:0]   wb_esubcode;
    logic [3:0]   tlb_op, tlbsrch_idx;
`ifdef WB_DEBUG_TRACE_EN
    logic [31:0]  debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]   debug_wb_rf_we;
    logic [4:0]   debug_wb_rf_wnum;
`endif

    int   checks = 0;
    int   errors = 0;
    ins_t held;     // model of the instruction held in WB
    logic hv;       // model of WB valid

    wb_stage dut (
        .clk(clk), .resetn(resetn),
        .MEM_to_WB_valid(MEM_to_WB_valid), .MEM_to_WB_bus(MEM_to_WB_bus),
        .WB_allow_in(WB_allow_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .WB_wr_bus(WB_wr_bus),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_badv_we(wb_badv_we),
        .ertn_flush(ertn_flush), .refetch_flush(refetch_flush), .refetch_pc(refetch_pc),
        .tlb_op(tlb_op), .tlbsrch_hit(tlbsrch_hit), .tlbsrch_idx(tlbsrch_idx),
        .flush(flush)
`ifdef WB_DEBUG_TRACE_EN
       ,.debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compare every output against the model's view of the held instruction.
    task automatic check_out(input string ctx);
        int          win = -1;
        logic        ex, ok, fetch, mem, e_rf, e_csr, e_ertn, e_ref;
        logic [3:0]  e_tlb;
        logic [31:0] e_rpc;
        for (int i = 0; i < 15; i++) if (win < 0 && held.ex_type[i]) win = i;
        ex    = hv && (win >= 0);
        ok    = hv && !ex;
        fetch = ex && win >= 1 && win <= 4;
        mem   = ex && win >= 8;
        e_rf  = ok && held.gr_we;
        e_csr = ok && held.csr_we;
        e_ertn = ok && held.ertn;
        e_ref  = ok && held.refetch;
        e_tlb  = ok ? {held.tlbsrch, held.tlbrd, held.tlbwr, held.tlbfill} : 4'h0;
        e_rpc  = held.pc + 32'd4;

        check({ctx, " allow_in"}, WB_allow_in, 1);
        check({ctx, " wb_ex"}, wb_ex, ex);
        check({ctx, " ecode"}, wb_ecode, ex ? ecode_tab[win] : 0);
        check({ctx, " esubcode"}, wb_esubcode, (ex && win == 9) ? 1 : 0);
        check({ctx, " wb_pc"}, wb_pc, ex ? held.pc : 0);
        check({ctx, " badv_we"}, wb_badv_we, fetch || mem);
        if (fetch)    check({ctx, " vaddr"}, wb_vaddr, held.pc);
        else if (mem) check({ctx, " vaddr"}, wb_vaddr, held.result);
        else if (!ex) check({ctx, " vaddr"}, wb_vaddr, 0);
        check({ctx, " rf_we"}, rf_we, e_rf);
        check({ctx, " wr_bus"}, WB_wr_bus, {e_rf, held.dest, held.result});
        if (e_rf) begin
            check({ctx, " rf_waddr"}, rf_waddr, held.dest);
            check({ctx, " rf_wdata"}, rf_wdata, held.result);
        end
        check({ctx, " csr_we"}, csr_we, e_csr);
        if (e_csr) begin
            check({ctx, " csr_num"}, csr_num, held.csr_num);
            check({ctx, " csr_wmask"}, csr_wmask, held.csr_wmask);
            check({ctx, " csr_wvalue"}, csr_wvalue, held.csr_wvalue);
        end
        check({ctx, " tlb_op"}, tlb_op, e_tlb);
        if (e_tlb[3]) begin
            check({ctx, " srch_hit"}, tlbsrch_hit, held.tlbhit);
            check({ctx, " srch_idx"}, tlbsrch_idx, held.hit_idx);
        end
        check({ctx, " ertn_flush"}, ertn_flush, e_ertn);
        check({ctx, " refetch_flush"}, refetch_flush, e_ref);
        if (e_ref) check({ctx, " refetch_pc"}, refetch_pc, e_rpc);
        check({ctx, " flush"}, flush, ex || e_ertn || e_ref);
`ifdef WB_DEBUG_TRACE_EN
        check({ctx, " dbg_we"}, debug_wb_rf_we, {4{e_rf}});
        check({ctx, " dbg_wnum"}, debug_wb_rf_wnum, held.dest);
        check({ctx, " dbg_wdata"}, debug_wb_rf_wdata, held.result);
        if (hv) check({ctx, " dbg_pc"}, debug_wb_pc, held.pc);
`endif
    endtask

    // One MEM->WB hand-off, then check the commit one edge later.
    task automatic step(input string ctx, input logic v, input ins_t ins);
        @(negedge clk);
        MEM_to_WB_valid = v;
        MEM_to_WB_bus   = ins;
        @(posedge clk);
        #1;
        if (v) held = ins;
        hv = v;
        check_out(ctx);
    endtask

    function automatic ins_t rand_ins();
        ins_t r;
        r = '0;
        {r.refetch, r.tlbsrch, r.tlbrd, r.tlbwr, r.tlbfill, r.tlbhit} = 6'($urandom_range(63)) & 6'($urandom);
        r.hit_idx    = 4'($urandom);
        r.csr_we     = 1'($urandom);
        r.csr_num    = 14'($urandom);
        r.csr_wmask  = $urandom;
        r.csr_wvalue = $urandom;
        r.ertn       = 1'($urandom);
        case ($urandom_range(3))
            0, 3:    r.ex_type = '0;
            1:       r.ex_type = 15'(1) << $urandom_range(14);
            default: r.ex_type = 15'($urandom);
        endcase
        r.result = $urandom;
        r.gr_we  = 1'($urandom);
        r.dest   = 5'($urandom);
        r.pc     = $urandom;
        r.inst   = $urandom;
        return r;
    endfunction

    initial begin
        ins_t i;
        held = '0;
        hv   = 1'b0;

        // Reset held from time zero.
        #2 check_out("por");
        @(negedge clk) resetn = 1'b1;

        // Mid-run reset while a valid instruction is committing.
        i = '0; i.gr_we = 1; i.dest = 5'd9; i.result = 32'hDEAD; i.pc = 32'h1C000000;
        i.csr_we = 1; i.refetch = 1; i.tlbwr = 1;
        step("pre_rst", 1, i);
        #3 resetn = 1'b0;
        #1 held = '0; hv = 0;
        check_out("mid_rst");
        @(posedge clk) #1 check_out("rst_held");
        @(negedge clk) begin resetn = 1'b1; MEM_to_WB_valid = 0; end

        // add r4 = 0x1234 after release.
        i = '0; i.gr_we = 1; i.dest = 5'd4; i.result = 32'h1234; i.pc = 32'h1C000004;
        step("add_r4", 1, i);

        // ALE|SYS: SYS wins, no badv, no commit.
        i = '0; i.ex_type = (15'(1) << 8) | (15'(1) << 6); i.pc = 32'h1C000100;
        i.result = 32'h3; i.gr_we = 1; i.csr_we = 1;
        step("ale_sys", 1, i);

        // ADEM only.
        i = '0; i.ex_type = 15'(1) << 9; i.result = 32'h80000001; i.pc = 32'h1C000200;
        step("adem", 1, i);

        // ERTN alone, then ERTN with INE.
        i = '0; i.ertn = 1; i.pc = 32'h1C000300;
        step("ertn", 1, i);
        i.ex_type = 15'(1) << 5;
        step("ertn_ine", 1, i);

        // TLBWR + refetch at the top of the address space.
        i = '0; i.tlbwr = 1; i.refetch = 1; i.pc = 32'hFFFFFFFC;
        step("tlbwr_wrap", 1, i);

        // TLBSRCH hit forwarded.
        i = '0; i.tlbsrch = 1; i.tlbhit = 1; i.hit_idx = 4'hA; i.pc = 32'h1C000400;
        step("tlbsrch", 1, i);

        // Stale bus with MEM valid low: nothing commits, register holds.
        i = '0; i.gr_we = 1; i.csr_we = 1; i.csr_num = 14'h5; i.dest = 5'd7;
        i.result = 32'h77; i.pc = 32'h1C000500;
        step("load", 1, i);
        i.dest = 5'd30; i.result = 32'hFFFF; i.tlbrd = 1; i.refetch = 1;
        step("bubble", 0, i);
        step("bubble2", 0, rand_ins());

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(3) != 0), rand_ins());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
